// File: rtl/wb_retire_trace.sv
// Write-back stage: registers the dual-slot MEM->WB bus, drives the RF and HI/LO ports,
// and serialises retired instructions onto the single-lane debug trace through a retire queue.
module wb_retire_trace #(
    parameter int unsigned QDEPTH   = 8,
    parameter int unsigned ENTRY_WD = 70
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         stall_i,
    input  logic [271:0] mem_to_wb_bus,
    output logic [75:0]  wb_to_rf_bus,
    output logic [65:0]  wb_to_hilo_bus,
    output logic         stallreq_trace,
    output logic [31:0]  debug_wb_pc,
    output logic [3:0]   debug_wb_rf_wen,
    output logic [4:0]   debug_wb_rf_wnum,
    output logic [31:0]  debug_wb_rf_wdata
);

    localparam int unsigned SLOT_WD = 136;
    localparam int unsigned PW      = $clog2(QDEPTH);
    localparam int unsigned CW      = PW + 1;

    logic [271:0]        wb_reg;
    logic [SLOT_WD-1:0]  s1, s2;
    logic [65:0]         h1, h2;
    logic                v1, v2;
    logic [ENTRY_WD-1:0] e1, e2, head;
    logic [ENTRY_WD-1:0] mem [QDEPTH];
    logic [PW-1:0]       wp, rp;
    logic [CW-1:0]       count;
    logic [CW-1:0]       push_cnt;
    logic                pop;

    // WB pipeline register; flush and upstream stall both insert a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_reg <= '0;
        end else if (flush || stall_i) begin
            wb_reg <= '0;
        end else begin
            wb_reg <= mem_to_wb_bus;
        end
    end

    assign s1 = wb_reg[135:0];
    assign s2 = wb_reg[271:136];
    assign h1 = s1[135:70];
    assign h2 = s2[135:70];
    assign v1 = |s1[69:38];
    assign v2 = |s2[69:38];
    assign e1 = s1[ENTRY_WD-1:0];
    assign e2 = s2[ENTRY_WD-1:0];

    // Both slots forwarded untouched; the regfile resolves same-address conflicts
    assign wb_to_rf_bus = {s2[37:0], s1[37:0]};

    // HI and LO each take slot2 when slot2 writes them, otherwise slot1
    assign wb_to_hilo_bus = {h2[65] | h1[65],
                             h2[64] | h1[64],
                             h2[65] ? h2[63:32] : h1[63:32],
                             h2[64] ? h2[31:0]  : h1[31:0]};

    assign push_cnt       = CW'(v1) + CW'(v2);
    assign pop            = (count != '0);
    assign head           = mem[rp];
    assign stallreq_trace = (count >= CW'(QDEPTH - 2));

    // Queue storage; slot1 lands before slot2 when both retire together
    always_ff @(posedge clk) begin
        if (v1) begin
            mem[wp] <= e1;
        end
        if (v2) begin
            mem[v1 ? wp + PW'(1) : wp] <= e2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp                <= '0;
            rp                <= '0;
            count             <= '0;
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            wp    <= wp + PW'(push_cnt);
            rp    <= rp + PW'(pop);
            count <= count + push_cnt - CW'(pop);
            if (pop) begin
                debug_wb_pc       <= head[69:38];
                debug_wb_rf_wen   <= {4{head[37]}};
                debug_wb_rf_wnum  <= head[36:32];
                debug_wb_rf_wdata <= head[31:0];
            end else begin
                debug_wb_pc       <= '0;
                debug_wb_rf_wen   <= '0;
                debug_wb_rf_wnum  <= '0;
                debug_wb_rf_wdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_retire_trace.sv
// Scoreboard bench for wb_retire_trace: the driver queues expected trace entries on capture,
// a forked monitor pops and compares every trace cycle.
module tb_wb_retire_trace;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         stall_i;
    logic         stall_auto;
    logic [271:0] mem_to_wb_bus;
    logic [75:0]  wb_to_rf_bus;
    logic [65:0]  wb_to_hilo_bus;
    logic         stallreq_trace;
    logic [31:0]  debug_wb_pc;
    logic [3:0]   debug_wb_rf_wen;
    logic [4:0]   debug_wb_rf_wnum;
    logic [31:0]  debug_wb_rf_wdata;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          max_cnt = 0;
    bit          stall_seen = 1'b0;
    logic [72:0] exp_q[$];
    int          trace_cyc[$];

    // Emulated control unit answers the stall request in the same cycle
    assign stall_i = stall_auto ? stallreq_trace : 1'b0;

    wb_retire_trace dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .stall_i           (stall_i),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .wb_to_rf_bus      (wb_to_rf_bus),
        .wb_to_hilo_bus    (wb_to_hilo_bus),
        .stallreq_trace    (stallreq_trace),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [135:0] slot(input logic [65:0] hl, input logic [31:0] pc,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] wd);
        return {hl, pc, we, wa, wd};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic exp_push(input logic [135:0] s);
        if (s[69:38] != 32'd0)
            exp_q.push_back({s[69:38], {4{s[37]}}, s[36:32], s[31:0]});
    endtask

    // Drive one pair from a negedge; retried while the control unit holds the stage
    task automatic send(input logic [135:0] a, input logic [135:0] b);
        bit taken;
        int tries = 0;
        do begin
            mem_to_wb_bus = {b, a};
            taken = !flush && !stall_i && !rst;
            @(posedge clk);
            if (taken) begin
                exp_push(a);
                exp_push(b);
            end
            @(negedge clk);
            mem_to_wb_bus = '0;
            tries++;
            if (!taken && tries > 50) begin
                check("send_stuck_stalled", 128'(tries), 128'(0));
                taken = 1'b1;
            end
        end while (!taken);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 128'({wb_to_rf_bus, stallreq_trace}), 128'(0));
        check({name, "_hilo"}, 128'(wb_to_hilo_bus), 128'(0));
        check({name, "_dbg"}, 128'({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
                                    debug_wb_rf_wdata}), 128'(0));
    endtask

    task automatic monitor();
        logic [72:0] act;
        logic [72:0] e;
        forever begin
            @(negedge clk);
            if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
            if (stallreq_trace) stall_seen = 1'b1;
            act = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
            if (debug_wb_pc != 32'd0) begin
                trace_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_trace", 128'(act), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("trace", 128'(act), 128'(e));
                end
            end else begin
                check("trace_idle", 128'(act), 128'(0));
            end
        end
    endtask

    initial begin
        logic [135:0] a, b;
        rst = 1'b1;
        flush = 1'b0;
        stall_auto = 1'b0;
        mem_to_wb_bus = '0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_release");

        // Single slot: RF port one cycle after capture, trace two cycles later
        a = slot(66'd0, 32'hBFC00000, 1'b1, 5'd8, 32'h1234);
        send(a, '0);
        check("single_rf", 128'(wb_to_rf_bus), 128'({38'd0, 1'b1, 5'd8, 32'h1234}));
        drain();

        // Three back-to-back pairs trace on six consecutive cycles
        trace_cyc.delete();
        for (int i = 0; i < 3; i++)
            send(slot(66'd0, 32'h100 + 32'(8 * i), 1'b1, 5'(i + 1), 32'(i)),
                 slot(66'd0, 32'h104 + 32'(8 * i), 1'b1, 5'(i + 10), 32'(i + 100)));
        drain();
        check("dual_trace_n", 128'(trace_cyc.size()), 128'(6));
        if (trace_cyc.size() == 6)
            check("dual_consecutive", 128'(trace_cyc[5] - trace_cyc[0]), 128'(5));

        // Sustained dual issue with the control unit answering stallreq
        stall_auto = 1'b1;
        for (int i = 0; i < 10; i++)
            send(slot(66'd0, 32'h1000 + 32'(8 * i), 1'b1, 5'(i), 32'hA000 + 32'(i)),
                 slot(66'd0, 32'h1004 + 32'(8 * i), 1'b0, 5'(i + 16), 32'hB000 + 32'(i)));
        drain();
        stall_auto = 1'b0;
        check("stallreq_seen", 128'(stall_seen), 128'(1));
        check("queue_peak", 128'(max_cnt), 128'(7));
        check("stallreq_idle", 128'(stallreq_trace), 128'(0));

        // Same destination from both slots
        a = slot(66'd0, 32'h200, 1'b1, 5'd3, 32'hAA);
        b = slot(66'd0, 32'h204, 1'b1, 5'd3, 32'hBB);
        send(a, b);
        check("same_dest_rf", 128'(wb_to_rf_bus),
              128'({1'b1, 5'd3, 32'hBB, 1'b1, 5'd3, 32'hAA}));
        drain();

        // HI/LO merge
        a = slot({1'b1, 1'b0, 32'd5, 32'd0}, 32'h300, 1'b0, 5'd0, 32'd0);
        b = slot({1'b0, 1'b1, 32'd0, 32'd7}, 32'h304, 1'b0, 5'd0, 32'd0);
        send(a, b);
        check("hilo_merge", 128'(wb_to_hilo_bus), 128'({1'b1, 1'b1, 32'd5, 32'd7}));
        b = slot({1'b1, 1'b1, 32'd9, 32'd7}, 32'h30C, 1'b0, 5'd0, 32'd0);
        a = slot({1'b1, 1'b0, 32'd5, 32'd0}, 32'h308, 1'b0, 5'd0, 32'd0);
        send(a, b);
        check("hilo_slot2_hi", 128'(wb_to_hilo_bus), 128'({1'b1, 1'b1, 32'd9, 32'd7}));
        drain();

        // Flush bubbles the WB register but queued entries still trace
        for (int i = 0; i < 3; i++)
            send(slot(66'd0, 32'h400 + 32'(8 * i), 1'b1, 5'(i + 4), 32'hC0 + 32'(i)),
                 slot(66'd0, 32'h404 + 32'(8 * i), 1'b1, 5'(i + 20), 32'hD0 + 32'(i)));
        mem_to_wb_bus = {slot(66'd1, 32'h51C, 1'b1, 5'd1, 32'd1),
                         slot(66'd1, 32'h518, 1'b1, 5'd2, 32'd2)};
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        mem_to_wb_bus = '0;
        check("flush_rf", 128'(wb_to_rf_bus), 128'(0));
        check("flush_hilo", 128'(wb_to_hilo_bus), 128'(0));
        drain();

        // Async reset with five queued entries discards them
        for (int i = 0; i < 4; i++)
            send(slot(66'd0, 32'h600 + 32'(8 * i), 1'b1, 5'(i), 32'(i)),
                 slot(66'd0, 32'h604 + 32'(8 * i), 1'b1, 5'(i), 32'(i)));
        send('0, '0);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        a = slot(66'd0, 32'h700, 1'b1, 5'd9, 32'h77);
        send(a, '0);
        drain();

        check("final_peak", 128'(max_cnt), 128'(7));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
